// File: rtl/dmem_port_arbiter_if.sv
// dmem_port_arbiter_if
//   Bundles every bus signal around the data-memory port arbiter: the two
//   load lanes, the store-buffer head, the registered RAM command, the RAM
//   read data and the drain status.
//
//   Handshake rules: a requester (ld_reqX, sb_valid) raises its request
//   together with stable address/data and holds it unchanged until the
//   matching grant (ld_gntX, sb_pop) is seen. A transfer happens in exactly
//   the cycle where request and grant are both 1. The grant is
//   combinational, and at most one of ld_gnt1, ld_gnt2 and sb_pop is high
//   in any cycle.
//
//   Modports:
//     slave  - the arbiter's view (requests in, grants/RAM command out)
//     master - the surrounding pipeline, store buffer and RAM
interface dmem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          ld_req1;
    logic [AW-1:0] ld_addr1;
    logic          ld_req2;
    logic [AW-1:0] ld_addr2;
    logic          ld_gnt1;
    logic          ld_gnt2;
    logic          ld_valid1;
    logic          ld_valid2;
    logic [DW-1:0] ld_rdata;
    logic          sb_valid;
    logic [AW-1:0] sb_addr;
    logic [DW-1:0] sb_data;
    logic          sb_full;
    logic          sb_pop;
    logic          mem_re;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mode_drain;

    modport slave (
        input  ld_req1, ld_addr1, ld_req2, ld_addr2,
        input  sb_valid, sb_addr, sb_data, sb_full, mem_rdata,
        output ld_gnt1, ld_gnt2, ld_valid1, ld_valid2, ld_rdata, sb_pop,
        output mem_re, mem_we, mem_addr, mem_wdata, mode_drain
    );

    modport master (
        output ld_req1, ld_addr1, ld_req2, ld_addr2,
        output sb_valid, sb_addr, sb_data, sb_full, mem_rdata,
        input  ld_gnt1, ld_gnt2, ld_valid1, ld_valid2, ld_rdata, sb_pop,
        input  mem_re, mem_we, mem_addr, mem_wdata, mode_drain
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares one synchronous-read data-RAM port between two load lanes and
//   the store-buffer drain. In NORMAL mode loads win (round-robin when both
//   lanes request) and stores use idle cycles. When a committed store has
//   been denied for STARVE_MAX consecutive cycles, or the store buffer is
//   full, the arbiter switches to DRAIN mode, which serves only stores
//   until at least DRAIN_MIN have retired (and the buffer is no longer
//   full) or the buffer runs empty.
//
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous, active-low reset
//     bus  - dmem_port_arbiter_if.slave (load lanes, store head, RAM
//            command, read data, mode_drain status)
//
//   Timing: a grant in cycle N drives the registered RAM command in N+1.
//   A load granted in N returns ld_validX/ld_rdata in N+2.
//
//   Optional feature, macro ARB_PERF_CNT_EN: adds the 32-bit wrapping
//   counters perf_ld_cnt (load grants), perf_st_cnt (store pops) and
//   perf_drain_cnt (NORMAL->DRAIN entries) as extra output ports.
module dmem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4,
    parameter int DRAIN_MIN  = 2
) (
    input  logic               clk,
    input  logic               rst,
    dmem_port_arbiter_if.slave bus
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]        perf_ld_cnt,
    output logic [31:0]        perf_st_cnt,
    output logic [31:0]        perf_drain_cnt
`endif
);

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_DRAIN  = 1'b1
    } state_e;

    localparam logic [3:0] STARVE_MAX_C = 4'(STARVE_MAX);
    localparam logic [2:0] DRAIN_MIN_C  = 3'(DRAIN_MIN);

    state_e        state_q, state_d;
    logic          rr_q, rr_d;
    logic [3:0]    starve_q, starve_d;
    logic [2:0]    drain_q, drain_d;
    logic          mem_re_q, mem_re_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    // Lane tag travels with the read command (stage 1) and then becomes
    // the read-data valid (stage 2), matching the RAM's one-cycle latency.
    logic          tag1_q, tag1_d;
    logic          tag2_q, tag2_d;
    logic          vld1_q, vld1_d;
    logic          vld2_q, vld2_d;

    logic          gnt1;
    logic          gnt2;
    logic          pop;

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        starve_d = starve_q;
        drain_d  = drain_q;
        gnt1     = 1'b0;
        gnt2     = 1'b0;
        pop      = 1'b0;

        if (state_q == ST_NORMAL) begin
            if (bus.ld_req1 && bus.ld_req2) begin
                gnt1 = !rr_q;
                gnt2 = rr_q;
                rr_d = !rr_q;
            end else if (bus.ld_req1) begin
                gnt1 = 1'b1;
            end else if (bus.ld_req2) begin
                gnt2 = 1'b1;
            end else begin
                pop = bus.sb_valid;
            end
        end else begin
            pop = bus.sb_valid;
        end

        if (!bus.sb_valid || pop) begin
            starve_d = 4'd0;
        end else if (starve_q != STARVE_MAX_C) begin
            starve_d = starve_q + 4'd1;
        end

        if (pop && (drain_q != 3'd7)) begin
            drain_d = drain_q + 3'd1;
        end

        // Entry uses the next starve value so DRAIN starts right after the
        // STARVE_MAX-th denied cycle; exit uses the registered drain count.
        if (state_q == ST_NORMAL) begin
            if (bus.sb_full || (starve_d == STARVE_MAX_C)) begin
                state_d = ST_DRAIN;
                drain_d = 3'd0;
            end
        end else begin
            if (!bus.sb_valid || ((drain_q >= DRAIN_MIN_C) && !bus.sb_full)) begin
                state_d  = ST_NORMAL;
                starve_d = 4'd0;
            end
        end
    end

    always_comb begin
        mem_re_d    = gnt1 || gnt2;
        mem_we_d    = pop;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        if (gnt1) begin
            mem_addr_d = bus.ld_addr1;
        end else if (gnt2) begin
            mem_addr_d = bus.ld_addr2;
        end else if (pop) begin
            mem_addr_d  = bus.sb_addr;
            mem_wdata_d = bus.sb_data;
        end
        tag1_d = gnt1;
        tag2_d = gnt2;
        vld1_d = tag1_q;
        vld2_d = tag2_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_NORMAL;
            rr_q        <= 1'b0;
            starve_q    <= 4'd0;
            drain_q     <= 3'd0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            tag1_q      <= 1'b0;
            tag2_q      <= 1'b0;
            vld1_q      <= 1'b0;
            vld2_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            starve_q    <= starve_d;
            drain_q     <= drain_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            tag1_q      <= tag1_d;
            tag2_q      <= tag2_d;
            vld1_q      <= vld1_d;
            vld2_q      <= vld2_d;
        end
    end

    assign bus.ld_gnt1    = gnt1;
    assign bus.ld_gnt2    = gnt2;
    assign bus.sb_pop     = pop;
    assign bus.mem_re     = mem_re_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.ld_valid1  = vld1_q;
    assign bus.ld_valid2  = vld2_q;
    // Read data is forced to zero outside its valid cycle.
    assign bus.ld_rdata   = (vld1_q || vld2_q) ? bus.mem_rdata : '0;
    assign bus.mode_drain = (state_q == ST_DRAIN);

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_ld_q, perf_ld_d;
    logic [31:0] perf_st_q, perf_st_d;
    logic [31:0] perf_dr_q, perf_dr_d;

    always_comb begin
        perf_ld_d = perf_ld_q;
        perf_st_d = perf_st_q;
        perf_dr_d = perf_dr_q;
        if (gnt1 || gnt2) begin
            perf_ld_d = perf_ld_q + 32'd1;
        end
        if (pop) begin
            perf_st_d = perf_st_q + 32'd1;
        end
        if ((state_q == ST_NORMAL) && (state_d == ST_DRAIN)) begin
            perf_dr_d = perf_dr_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_ld_q <= 32'd0;
            perf_st_q <= 32'd0;
            perf_dr_q <= 32'd0;
        end else begin
            perf_ld_q <= perf_ld_d;
            perf_st_q <= perf_st_d;
            perf_dr_q <= perf_dr_d;
        end
    end

    assign perf_ld_cnt    = perf_ld_q;
    assign perf_st_cnt    = perf_st_q;
    assign perf_drain_cnt = perf_dr_q;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter
//   Directed testbench for dmem_port_arbiter with a small synchronous-read
//   RAM model. Inputs change 1 time unit after a rising edge; outputs are
//   compared 1 unit later, well away from the next edge.
module tb_dmem_port_arbiter;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    dmem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_ld_cnt;
    logic [31:0] perf_st_cnt;
    logic [31:0] perf_drain_cnt;
`endif

    dmem_port_arbiter #(
        .AW(32), .DW(32), .STARVE_MAX(4), .DRAIN_MIN(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
`ifdef ARB_PERF_CNT_EN
        ,
        .perf_ld_cnt    (perf_ld_cnt),
        .perf_st_cnt    (perf_st_cnt),
        .perf_drain_cnt (perf_drain_cnt)
`endif
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- RAM model (word addressed by addr[9:2]) ----------------
    logic [31:0] ram [0:255];
    logic        bd_we;
    logic [31:0] bd_addr;
    logic [31:0] bd_data;

    always @(posedge clk) begin
        if (bd_we) ram[bd_addr[9:2]] <= bd_data;
        if (bus.mem_we) ram[bus.mem_addr[9:2]] <= bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= ram[bus.mem_addr[9:2]];
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ld_req1  = 1'b0;
        bus.ld_addr1 = '0;
        bus.ld_req2  = 1'b0;
        bus.ld_addr2 = '0;
        bus.sb_valid = 1'b0;
        bus.sb_addr  = '0;
        bus.sb_data  = '0;
        bus.sb_full  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic ram_poke(input logic [31:0] a, input logic [31:0] d);
        bd_we   = 1'b1;
        bd_addr = a;
        bd_data = d;
        tick();
        bd_we   = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++;
            if ({bus.mem_re, bus.mem_we, bus.ld_valid1, bus.ld_valid2, bus.mode_drain} !== 5'b0) begin
                bad++;
                $display("FAIL reset_ctrl got=%b exp=00000",
                         {bus.mem_re, bus.mem_we, bus.ld_valid1, bus.ld_valid2, bus.mode_drain});
            end
            total++;
            if ({bus.mem_addr, bus.mem_wdata, bus.ld_rdata} !== 96'b0) begin
                bad++;
                $display("FAIL reset_data got=%h/%h/%h exp=0", bus.mem_addr, bus.mem_wdata, bus.ld_rdata);
            end
            tick();
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_load();
        do_reset();
        ram_poke(32'h40, 32'hDEADBEEF);
        bus.ld_req1  = 1'b1;
        bus.ld_addr1 = 32'h40;
        #1;
        total++;
        if ({bus.ld_gnt1, bus.ld_gnt2, bus.sb_pop} !== 3'b100) begin
            bad++;
            $display("FAIL single_gnt got=%b exp=100", {bus.ld_gnt1, bus.ld_gnt2, bus.sb_pop});
        end
        tick();
        bus.ld_req1 = 1'b0;
        #1;
        total++;
        if ({bus.mem_re, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {2'b10, 32'h40, 32'h0}) begin
            bad++;
            $display("FAIL single_cmd got=%b %h %h exp=10 00000040 0",
                     {bus.mem_re, bus.mem_we}, bus.mem_addr, bus.mem_wdata);
        end
        tick();
        #1;
        total++;
        if ({bus.ld_valid1, bus.ld_valid2, bus.ld_rdata} !== {2'b10, 32'hDEADBEEF}) begin
            bad++;
            $display("FAIL single_data got=%b %h exp=10 deadbeef", {bus.ld_valid1, bus.ld_valid2}, bus.ld_rdata);
        end
        tick();
        #1;
        total++;
        if ({bus.ld_valid1, bus.ld_rdata} !== 33'b0) begin
            bad++;
            $display("FAIL single_after got=%b %h exp=0 0", bus.ld_valid1, bus.ld_rdata);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g;
        do_reset();
        bus.ld_addr1 = 32'h100;
        bus.ld_addr2 = 32'h200;
        bus.ld_req1  = 1'b1;
        bus.ld_req2  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            exp_g = (i % 2 == 0) ? 2'b10 : 2'b01;
            total++;
            if ({bus.ld_gnt1, bus.ld_gnt2} !== exp_g) begin
                bad++;
                $display("FAIL rr_gnt[%0d] got=%b exp=%b", i, {bus.ld_gnt1, bus.ld_gnt2}, exp_g);
            end
            if (i > 0) begin
                total++;
                if (bus.mem_addr !== ((i % 2 == 1) ? 32'h100 : 32'h200)) begin
                    bad++;
                    $display("FAIL rr_addr[%0d] got=%h", i, bus.mem_addr);
                end
            end
            tick();
        end
        // rr is back to 0; a lone lane-2 request must not move it.
        bus.ld_req1 = 1'b0;
        #1;
        total++;
        if ({bus.ld_gnt1, bus.ld_gnt2, bus.ld_valid1, bus.ld_valid2} !== 4'b0110) begin
            bad++;
            $display("FAIL rr_single got=%b exp=0110", {bus.ld_gnt1, bus.ld_gnt2, bus.ld_valid1, bus.ld_valid2});
        end
        tick();
        bus.ld_req1 = 1'b1;
        #1;
        total++;
        if ({bus.ld_gnt1, bus.ld_gnt2} !== 2'b10) begin
            bad++;
            $display("FAIL rr_hold got=%b exp=10", {bus.ld_gnt1, bus.ld_gnt2});
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_starvation();
        logic e_drain;
        logic p_drain;
        logic [1:0] exp_g;
        int n;
        do_reset();
        n = 0;
        p_drain = 1'b0;
        bus.ld_addr1 = 32'h100;
        bus.ld_addr2 = 32'h200;
        bus.ld_req1  = 1'b1;
        bus.ld_req2  = 1'b1;
        bus.sb_valid = 1'b1;
        bus.sb_addr  = 32'h300;
        bus.sb_data  = 32'hA5A50001;
        for (int c = 0; c < 12; c++) begin
            #1;
            e_drain = (c >= 4 && c <= 6) || (c == 11);
            exp_g = e_drain ? 2'b00 : ((n % 2 == 0) ? 2'b10 : 2'b01);
            if (!e_drain) n++;
            total++;
            if ({bus.mode_drain, bus.sb_pop, bus.ld_gnt1, bus.ld_gnt2} !== {e_drain, e_drain, exp_g}) begin
                bad++;
                $display("FAIL starve_c%0d got=%b exp=%b", c,
                         {bus.mode_drain, bus.sb_pop, bus.ld_gnt1, bus.ld_gnt2}, {e_drain, e_drain, exp_g});
            end
            if (c > 0) begin
                total++;
                if ({bus.mem_re, bus.mem_we} !== {!p_drain, p_drain}) begin
                    bad++;
                    $display("FAIL starve_cmd_c%0d got=%b exp=%b", c, {bus.mem_re, bus.mem_we}, {!p_drain, p_drain});
                end
            end
            if (c == 5) begin
                total++;
                if ({bus.mem_addr, bus.mem_wdata} !== {32'h300, 32'hA5A50001}) begin
                    bad++;
                    $display("FAIL starve_wr got=%h %h exp=300 a5a50001", bus.mem_addr, bus.mem_wdata);
                end
            end
            p_drain = e_drain;
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_full_drain();
        logic [31:0] sa_q[$];
        logic [31:0] sd_q[$];
        logic [31:0] exp_q[$];
        logic [31:0] exd_q[$];
        logic e_drain;
        logic [1:0] exp_g;
        logic [1:0] exp_v;
        int n;
        int we_seen;
        do_reset();
        sa_q  = '{32'h400, 32'h404, 32'h408};
        sd_q  = '{32'h1111, 32'h2222, 32'h3333};
        exp_q = sa_q;
        exd_q = sd_q;
        n = 0;
        we_seen = 0;
        bus.ld_addr1 = 32'h500;
        bus.ld_addr2 = 32'h504;
        bus.ld_req1  = 1'b1;
        bus.ld_req2  = 1'b1;
        for (int c = 0; c < 7; c++) begin
            bus.sb_valid = (sa_q.size() > 0);
            bus.sb_addr  = (sa_q.size() > 0) ? sa_q[0] : 32'h0;
            bus.sb_data  = (sd_q.size() > 0) ? sd_q[0] : 32'h0;
            bus.sb_full  = (sa_q.size() == 3);
            #1;
            e_drain = (c >= 1 && c <= 3);
            exp_g = e_drain ? 2'b00 : ((n % 2 == 0) ? 2'b10 : 2'b01);
            if (!e_drain) n++;
            exp_v = (c == 2) ? 2'b10 : ((c == 6) ? 2'b01 : 2'b00);
            total++;
            if ({bus.mode_drain, bus.sb_pop, bus.ld_gnt1, bus.ld_gnt2} !== {e_drain, e_drain, exp_g}) begin
                bad++;
                $display("FAIL full_c%0d got=%b exp=%b", c,
                         {bus.mode_drain, bus.sb_pop, bus.ld_gnt1, bus.ld_gnt2}, {e_drain, e_drain, exp_g});
            end
            total++;
            if ({bus.ld_valid1, bus.ld_valid2} !== exp_v) begin
                bad++;
                $display("FAIL full_vld_c%0d got=%b exp=%b", c, {bus.ld_valid1, bus.ld_valid2}, exp_v);
            end
            if (bus.mem_we) begin
                we_seen++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL full_extra_wr got=%h exp=none", bus.mem_addr);
                end else if ({bus.mem_addr, bus.mem_wdata, bus.mem_re} !== {exp_q[0], exd_q[0], 1'b0}) begin
                    bad++;
                    $display("FAIL full_wr got=%h %h re=%b exp=%h %h re=0",
                             bus.mem_addr, bus.mem_wdata, bus.mem_re, exp_q[0], exd_q[0]);
                end
                if (exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    void'(exd_q.pop_front());
                end
            end
            if (e_drain && sa_q.size() > 0) begin
                void'(sa_q.pop_front());
                void'(sd_q.pop_front());
            end
            tick();
        end
        total++;
        if (we_seen !== 3) begin
            bad++;
            $display("FAIL full_wr_count got=%0d exp=3", we_seen);
        end
        idle_inputs();
    endtask

    task automatic test_store_load_hazard();
        do_reset();
        ram_poke(32'h80, 32'hFFFF0000);
        bus.sb_valid = 1'b1;
        bus.sb_addr  = 32'h80;
        bus.sb_data  = 32'h12345678;
        #1;
        total++;
        if ({bus.sb_pop, bus.ld_gnt1, bus.ld_gnt2} !== 3'b100) begin
            bad++;
            $display("FAIL haz_pop got=%b exp=100", {bus.sb_pop, bus.ld_gnt1, bus.ld_gnt2});
        end
        tick();
        bus.sb_valid = 1'b0;
        bus.ld_req1  = 1'b1;
        bus.ld_addr1 = 32'h80;
        #1;
        total++;
        if ({bus.ld_gnt1, bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata} !== {3'b110, 32'h80, 32'h12345678}) begin
            bad++;
            $display("FAIL haz_wr got=%b %h %h", {bus.ld_gnt1, bus.mem_we, bus.mem_re}, bus.mem_addr, bus.mem_wdata);
        end
        tick();
        bus.ld_req1 = 1'b0;
        tick();
        #1;
        total++;
        if ({bus.ld_valid1, bus.ld_rdata} !== {1'b1, 32'h12345678}) begin
            bad++;
            $display("FAIL haz_rd got=%b %h exp=1 12345678", bus.ld_valid1, bus.ld_rdata);
        end
        tick();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        bus.ld_req1  = 1'b1;
        bus.ld_addr1 = 32'h40;
        #1;
        total++;
        if (bus.ld_gnt1 !== 1'b1) begin
            bad++;
            $display("FAIL mid_gnt got=%b exp=1", bus.ld_gnt1);
        end
        tick();
        bus.ld_req1 = 1'b0;
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            total++;
            if ({bus.mem_re, bus.mem_we, bus.ld_valid1, bus.ld_valid2, bus.mode_drain, bus.mem_addr, bus.ld_rdata} !== 69'b0) begin
                bad++;
                $display("FAIL mid_rst_c%0d got=%b %h %h", c,
                         {bus.mem_re, bus.mem_we, bus.ld_valid1, bus.ld_valid2, bus.mode_drain}, bus.mem_addr, bus.ld_rdata);
            end
            tick();
        end
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            total++;
            if ({bus.ld_valid1, bus.ld_valid2, bus.mem_re} !== 3'b000) begin
                bad++;
                $display("FAIL mid_after_c%0d got=%b exp=000", c, {bus.ld_valid1, bus.ld_valid2, bus.mem_re});
            end
            tick();
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        total = 0;
        bad   = 0;
        bd_we = 1'b0;
        bd_addr = '0;
        bd_data = '0;
        bus.mem_rdata = '0;
        idle_inputs();
        rst = 1'b1;
        #2;
        test_reset();
        test_single_load();
        test_round_robin();
        test_starvation();
        test_full_drain();
        test_store_load_hazard();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
